// File: rtl/axi4_region_map_decoder_if.sv
// ============================================================================
// Module   : axi4_region_map_decoder_if
// Purpose  : Bundles the table-programming, decode-request and decode-response
//            signals of axi4_region_map_decoder. The slave modport is the
//            decoder side; the master modport is the requester side.
//            Statistics signals exist only when AXI4_RGN_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface axi4_region_map_decoder_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_REGIONS  = 16,
  parameter int REGION_WIDTH = 4,
  parameter int NUM_CH       = 2
`ifdef AXI4_RGN_STATS_EN
  , parameter int CNT_WIDTH  = 16
`endif
);
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  // Table programming
  logic                          cfg_valid;
  logic [IDX_W-1:0]              cfg_idx;
  logic [ADDR_WIDTH-1:0]         cfg_base;
  logic [ADDR_WIDTH-1:0]         cfg_limit;
  logic [REGION_WIDTH-1:0]       cfg_region;
  logic                          cfg_enable;
  logic                          cfg_lock;
  logic                          cfg_err;

  // Decode request, one lane per channel
  logic [NUM_CH-1:0]             dec_valid;
  logic [NUM_CH-1:0]             dec_ready;
  logic [NUM_CH*ADDR_WIDTH-1:0]  dec_addr;
  logic [NUM_CH*8-1:0]           dec_len;
  logic [NUM_CH*3-1:0]           dec_size;

  // Decode response, one lane per channel
  logic [NUM_CH-1:0]             rsp_valid;
  logic [NUM_CH-1:0]             rsp_ready;
  logic [NUM_CH*REGION_WIDTH-1:0] rsp_region;
  logic [NUM_CH-1:0]             rsp_hit;
  logic [NUM_CH-1:0]             rsp_multi;
  logic [NUM_CH-1:0]             rsp_span_err;

`ifdef AXI4_RGN_STATS_EN
  logic [NUM_CH*CNT_WIDTH-1:0]   stat_miss;
  logic [NUM_CH*CNT_WIDTH-1:0]   stat_multi;
  logic [NUM_CH*CNT_WIDTH-1:0]   stat_span;

  modport slave (
    input  cfg_valid, cfg_idx, cfg_base, cfg_limit, cfg_region, cfg_enable, cfg_lock,
    output cfg_err,
    input  dec_valid, dec_addr, dec_len, dec_size,
    output dec_ready,
    input  rsp_ready,
    output rsp_valid, rsp_region, rsp_hit, rsp_multi, rsp_span_err,
    output stat_miss, stat_multi, stat_span
  );

  modport master (
    output cfg_valid, cfg_idx, cfg_base, cfg_limit, cfg_region, cfg_enable, cfg_lock,
    input  cfg_err,
    output dec_valid, dec_addr, dec_len, dec_size,
    input  dec_ready,
    output rsp_ready,
    input  rsp_valid, rsp_region, rsp_hit, rsp_multi, rsp_span_err,
    input  stat_miss, stat_multi, stat_span
  );
`else
  modport slave (
    input  cfg_valid, cfg_idx, cfg_base, cfg_limit, cfg_region, cfg_enable, cfg_lock,
    output cfg_err,
    input  dec_valid, dec_addr, dec_len, dec_size,
    output dec_ready,
    input  rsp_ready,
    output rsp_valid, rsp_region, rsp_hit, rsp_multi, rsp_span_err
  );

  modport master (
    output cfg_valid, cfg_idx, cfg_base, cfg_limit, cfg_region, cfg_enable, cfg_lock,
    input  cfg_err,
    output dec_valid, dec_addr, dec_len, dec_size,
    input  dec_ready,
    output rsp_ready,
    input  rsp_valid, rsp_region, rsp_hit, rsp_multi, rsp_span_err
  );
`endif

endinterface

`default_nettype wire

// File: rtl/axi4_region_map_decoder.sv
// ============================================================================
// Module   : axi4_region_map_decoder
// Purpose  : Multi-channel AXI4 AxREGION decoder. A programmable base/limit
//            table maps each (addr, len, size) request to a region and flags
//            miss, multi-match and burst-span errors. Each channel has its own
//            registered valid/ready response stage; all channels share the
//            table. A sticky lock freezes the table until reset.
//            Optional feature macro: AXI4_RGN_STATS_EN (per-channel saturating
//            miss / multi-match / span-error counters).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi4_region_map_decoder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_REGIONS    = 16,
  parameter int REGION_WIDTH   = 4,
  parameter int NUM_CH         = 2,
  parameter int DEFAULT_REGION = 0
`ifdef AXI4_RGN_STATS_EN
  , parameter int CNT_WIDTH    = 16
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  axi4_region_map_decoder_if.slave     bus
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  // Burst end is evaluated 12 bits wider than the address so wrap is visible
  localparam int EW    = ADDR_WIDTH + 12;
  localparam logic [EW-1:0]           c_ONE         = EW'(1);
  localparam logic [IDX_W:0]          c_NUM_REGIONS = (IDX_W + 1)'(NUM_REGIONS);
  localparam logic [REGION_WIDTH-1:0] c_DEF_REGION  = REGION_WIDTH'(DEFAULT_REGION);

  // Region table
  logic [ADDR_WIDTH-1:0]   base_q   [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0]   limit_q  [NUM_REGIONS];
  logic [REGION_WIDTH-1:0] region_q [NUM_REGIONS];
  logic [NUM_REGIONS-1:0]  enable_q;
  logic                    lock_q;
  logic                    cfg_err_q;
  logic                    w_cfg_reject;

  // Per-channel decode results
  logic [ADDR_WIDTH-1:0]   w_addr      [NUM_CH];
  logic [EW-1:0]           w_bytes     [NUM_CH];
  logic [EW-1:0]           w_end       [NUM_CH];
  logic [ADDR_WIDTH-1:0]   w_win_limit [NUM_CH];
  logic [REGION_WIDTH-1:0] w_region    [NUM_CH];
  logic [NUM_CH-1:0]       w_hit, w_multi, w_span;
  logic [NUM_CH-1:0]       w_dec_ready, w_xfer;

  // Response registers
  logic [NUM_CH-1:0]              rsp_valid_q, rsp_hit_q, rsp_multi_q, rsp_span_q;
  logic [NUM_CH*REGION_WIDTH-1:0] rsp_region_q;

  // A write is refused while locked, for an index past the table, or for an
  // enabled entry whose range is inverted
  assign w_cfg_reject = lock_q
                     || ({1'b0, bus.cfg_idx} >= c_NUM_REGIONS)
                     || (bus.cfg_enable && (bus.cfg_base > bus.cfg_limit));

  // Table write, sticky lock and one-cycle reject pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]   <= '0;
        limit_q[i]  <= '0;
        region_q[i] <= '0;
      end
      enable_q  <= '0;
      lock_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_valid && w_cfg_reject;
      if (bus.cfg_valid && !w_cfg_reject) begin
        base_q[bus.cfg_idx]   <= bus.cfg_base;
        limit_q[bus.cfg_idx]  <= bus.cfg_limit;
        region_q[bus.cfg_idx] <= bus.cfg_region;
        enable_q[bus.cfg_idx] <= bus.cfg_enable;
      end
      if (bus.cfg_lock) begin
        lock_q <= 1'b1;
      end
    end
  end

  // Table lookup and span check; scanning upward makes the first hit the winner
  always_comb begin
    w_hit   = '0;
    w_multi = '0;
    w_span  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_addr[c]      = bus.dec_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
      w_bytes[c]     = (EW'({1'b0, bus.dec_len[c*8 +: 8]}) + c_ONE) << bus.dec_size[c*3 +: 3];
      w_end[c]       = EW'(w_addr[c]) + w_bytes[c] - c_ONE;
      w_region[c]    = c_DEF_REGION;
      w_win_limit[c] = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (enable_q[i] && (base_q[i] <= w_addr[c]) && (w_addr[c] <= limit_q[i])) begin
          if (w_hit[c]) begin
            w_multi[c] = 1'b1;
          end else begin
            w_hit[c]       = 1'b1;
            w_region[c]    = region_q[i];
            w_win_limit[c] = limit_q[i];
          end
        end
      end
      w_span[c] = (w_end[c][EW-1:ADDR_WIDTH] != '0)
               || (w_end[c][ADDR_WIDTH-1:12] != w_addr[c][ADDR_WIDTH-1:12])
               || (w_hit[c] && (w_end[c] > EW'(w_win_limit[c])));
    end
  end

  assign w_dec_ready = ~rsp_valid_q | bus.rsp_ready;
  assign w_xfer      = bus.dec_valid & w_dec_ready;

  // Per-channel registered response stage; holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= '0;
      rsp_hit_q    <= '0;
      rsp_multi_q  <= '0;
      rsp_span_q   <= '0;
      rsp_region_q <= {NUM_CH{c_DEF_REGION}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_xfer[c]) begin
          rsp_valid_q[c]                             <= 1'b1;
          rsp_hit_q[c]                               <= w_hit[c];
          rsp_multi_q[c]                             <= w_multi[c];
          rsp_span_q[c]                              <= w_span[c];
          rsp_region_q[c*REGION_WIDTH +: REGION_WIDTH] <= w_region[c];
        end else if (bus.rsp_ready[c]) begin
          rsp_valid_q[c] <= 1'b0;
        end
      end
    end
  end

  assign bus.cfg_err      = cfg_err_q;
  assign bus.dec_ready    = w_dec_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_region   = rsp_region_q;
  assign bus.rsp_hit      = rsp_hit_q;
  assign bus.rsp_multi    = rsp_multi_q;
  assign bus.rsp_span_err = rsp_span_q;

`ifdef AXI4_RGN_STATS_EN
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  logic [NUM_CH*CNT_WIDTH-1:0] stat_miss_q, stat_multi_q, stat_span_q;

  // Saturating event counters advanced on each delivered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_miss_q  <= '0;
      stat_multi_q <= '0;
      stat_span_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rsp_valid_q[c] && bus.rsp_ready[c]) begin
          if (!rsp_hit_q[c] && (stat_miss_q[c*CNT_WIDTH +: CNT_WIDTH] != c_CNT_MAX))
            stat_miss_q[c*CNT_WIDTH +: CNT_WIDTH] <= stat_miss_q[c*CNT_WIDTH +: CNT_WIDTH] + c_CNT_ONE;
          if (rsp_multi_q[c] && (stat_multi_q[c*CNT_WIDTH +: CNT_WIDTH] != c_CNT_MAX))
            stat_multi_q[c*CNT_WIDTH +: CNT_WIDTH] <= stat_multi_q[c*CNT_WIDTH +: CNT_WIDTH] + c_CNT_ONE;
          if (rsp_span_q[c] && (stat_span_q[c*CNT_WIDTH +: CNT_WIDTH] != c_CNT_MAX))
            stat_span_q[c*CNT_WIDTH +: CNT_WIDTH] <= stat_span_q[c*CNT_WIDTH +: CNT_WIDTH] + c_CNT_ONE;
        end
      end
    end
  end

  assign bus.stat_miss  = stat_miss_q;
  assign bus.stat_multi = stat_multi_q;
  assign bus.stat_span  = stat_span_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi4_region_map_decoder.sv
// ============================================================================
// Module   : tb_axi4_region_map_decoder
// Purpose  : Self-checking bench for axi4_region_map_decoder. Directed
//            scenarios plus randomized streaming, checked against a table
//            model that decodes with plain arithmetic and index lists.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi4_region_map_decoder;

  localparam int AW  = 32;
  localparam int NR  = 16;
  localparam int RW  = 4;
  localparam int NCH = 2;
  localparam int DEF = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_region_map_decoder_if #(.ADDR_WIDTH(AW), .NUM_REGIONS(NR), .REGION_WIDTH(RW), .NUM_CH(NCH)) bus ();

  axi4_region_map_decoder #(
    .ADDR_WIDTH(AW), .NUM_REGIONS(NR), .REGION_WIDTH(RW), .NUM_CH(NCH), .DEFAULT_REGION(DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference table
  logic [31:0] m_base   [NR];
  logic [31:0] m_limit  [NR];
  logic [3:0]  m_region [NR];
  logic        m_en     [NR];
  logic        m_lock;
  logic        m_exp_err;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = '0; m_limit[i] = '0; m_region[i] = '0; m_en[i] = 1'b0;
    end
    m_lock    = 1'b0;
    m_exp_err = 1'b0;
  endfunction

  function automatic void model_write(int idx, logic [31:0] b, logic [31:0] l,
                                      logic [3:0] r, logic en, logic lk);
    m_exp_err = m_lock || (idx >= NR) || (en && (b > l));
    if (!m_exp_err) begin
      m_base[idx] = b; m_limit[idx] = l; m_region[idx] = r; m_en[idx] = en;
    end
    if (lk) m_lock = 1'b1;
  endfunction

  // Returns {region, hit, multi, span_err}
  function automatic logic [6:0] model_decode(logic [31:0] a, logic [7:0] len, logic [2:0] size);
    int     q[$];
    longint e;
    logic   hit, multi, span;
    logic [3:0] rg;
    e = longint'(a) + (longint'(len) + 1) * (longint'(1) << size) - 1;
    for (int i = 0; i < NR; i++)
      if (m_en[i] && (a >= m_base[i]) && (a <= m_limit[i])) q.push_back(i);
    hit   = (q.size() > 0);
    multi = (q.size() > 1);
    rg    = hit ? m_region[q[0]] : 4'(DEF);
    span  = (e > longint'(32'hFFFF_FFFF)) || ((e >> 12) != (longint'(a) >> 12))
         || (hit && (e > longint'(m_limit[q[0]])));
    return {rg, hit, multi, span};
  endfunction

  function automatic logic [6:0] rsp_of(int c);
    return {bus.rsp_region[c*RW +: RW], bus.rsp_hit[c], bus.rsp_multi[c], bus.rsp_span_err[c]};
  endfunction

  task automatic drive_req(int c, logic [31:0] a, logic [7:0] l, logic [2:0] s);
    bus.dec_valid[c]         = 1'b1;
    bus.dec_addr[c*AW +: AW] = a;
    bus.dec_len[c*8 +: 8]    = l;
    bus.dec_size[c*3 +: 3]   = s;
  endtask

  task automatic cfg_write(int idx, logic [31:0] b, logic [31:0] l, logic [3:0] r, logic en, logic lk);
    bus.cfg_valid  = 1'b1;
    bus.cfg_idx    = idx[3:0];
    bus.cfg_base   = b;
    bus.cfg_limit  = l;
    bus.cfg_region = r;
    bus.cfg_enable = en;
    bus.cfg_lock   = lk;
    @(posedge clk); #1;
    model_write(idx, b, l, r, en, lk);
    bus.cfg_valid = 1'b0;
    bus.cfg_lock  = 1'b0;
  endtask

  // One request, one cycle; response is visible when this returns
  task automatic send(int c, logic [31:0] a, logic [7:0] l, logic [2:0] s, output logic [6:0] exp);
    exp = model_decode(a, l, s);
    drive_req(c, a, l, s);
    @(posedge clk); #1;
    bus.dec_valid[c] = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.dec_valid = '0;
    bus.rsp_ready = '1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b expected 0", bus.cfg_err); else n_pass++;
    n_total++; if (bus.rsp_region !== {2{4'(DEF)}}) $display("FAIL reset_region: got %h expected %h", bus.rsp_region, {2{4'(DEF)}}); else n_pass++;
    n_total++; if ({bus.rsp_hit, bus.rsp_multi, bus.rsp_span_err} !== 6'b0) $display("FAIL reset_flags: got %b expected 000000", {bus.rsp_hit, bus.rsp_multi, bus.rsp_span_err}); else n_pass++;
    n_total++; if (bus.dec_ready !== 2'b11) $display("FAIL reset_dec_ready: got %b expected 11", bus.dec_ready); else n_pass++;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_basic_hit();
    logic [6:0] exp;
    cfg_write(2, 32'h1000, 32'h1FFF, 4'd5, 1'b1, 1'b0);
    n_total++; if (bus.cfg_err !== m_exp_err) $display("FAIL basic_cfg_err: got %b expected %b", bus.cfg_err, m_exp_err); else n_pass++;
    send(0, 32'h1800, 8'd0, 3'd2, exp);
    n_total++; if (bus.rsp_valid !== 2'b01) $display("FAIL basic_valid: got %b expected 01", bus.rsp_valid); else n_pass++;
    n_total++; if (rsp_of(0) !== exp) $display("FAIL basic_rsp: got %h expected %h", rsp_of(0), exp); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL basic_valid_drop: got %b expected 00", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_multi_match();
    logic [6:0] exp;
    cfg_write(1, 32'h0, 32'hFFFF, 4'd3, 1'b1, 1'b0);
    cfg_write(4, 32'h8000, 32'h8FFF, 4'd9, 1'b1, 1'b0);
    send(1, 32'h8010, 8'd0, 3'd0, exp);
    n_total++; if (rsp_of(1) !== exp) $display("FAIL multi_rsp: got %h expected %h", rsp_of(1), exp); else n_pass++;
    send(0, 32'h2_0000, 8'd1, 3'd1, exp);
    n_total++; if (rsp_of(0) !== exp) $display("FAIL miss_rsp: got %h expected %h", rsp_of(0), exp); else n_pass++;
  endtask

  task automatic test_span();
    logic [6:0] exp;
    send(0, 32'h1FF0, 8'd3, 3'd3, exp);
    n_total++; if (rsp_of(0) !== exp) $display("FAIL span_4k_cross: got %h expected %h", rsp_of(0), exp); else n_pass++;
    send(0, 32'h1F00, 8'd3, 3'd3, exp);
    n_total++; if (rsp_of(0) !== exp) $display("FAIL span_inside: got %h expected %h", rsp_of(0), exp); else n_pass++;
    send(1, 32'hFFFF_FFF0, 8'd3, 3'd3, exp);
    n_total++; if (rsp_of(1) !== exp) $display("FAIL span_overflow: got %h expected %h", rsp_of(1), exp); else n_pass++;
    cfg_write(6, 32'h3_0000, 32'h3_07FF, 4'd2, 1'b1, 1'b0);
    send(0, 32'h3_07F0, 8'd3, 3'd3, exp);
    n_total++; if (rsp_of(0) !== exp) $display("FAIL span_past_limit: got %h expected %h", rsp_of(0), exp); else n_pass++;
  endtask

  task automatic test_same_cycle_write();
    logic [6:0] exp_old, exp_new;
    cfg_write(0, 32'h5_0000, 32'h5_0FFF, 4'd6, 1'b1, 1'b0);
    exp_old = model_decode(32'h5_0010, 8'd0, 3'd2);
    bus.cfg_valid = 1'b1; bus.cfg_idx = 4'd0; bus.cfg_base = 32'h5_0000;
    bus.cfg_limit = 32'h5_0FFF; bus.cfg_region = 4'd11; bus.cfg_enable = 1'b1; bus.cfg_lock = 1'b0;
    drive_req(0, 32'h5_0010, 8'd0, 3'd2);
    @(posedge clk); #1;
    model_write(0, 32'h5_0000, 32'h5_0FFF, 4'd11, 1'b1, 1'b0);
    bus.cfg_valid = 1'b0; bus.dec_valid = '0;
    n_total++; if (rsp_of(0) !== exp_old) $display("FAIL same_cycle_old: got %h expected %h", rsp_of(0), exp_old); else n_pass++;
    send(0, 32'h5_0010, 8'd0, 3'd2, exp_new);
    n_total++; if (rsp_of(0) !== exp_new) $display("FAIL same_cycle_new: got %h expected %h", rsp_of(0), exp_new); else n_pass++;
  endtask

  task automatic test_random_stream();
    logic [6:0]  pend_exp [NCH];
    logic        pend_v   [NCH];
    logic [31:0] a, b;
    logic [7:0]  l;
    logic [2:0]  s;
    int          sel;
    for (int i = 8; i < 14; i++) begin
      b = 32'($urandom_range(0, 32'h3_FFFF));
      cfg_write(i, b, b + 32'($urandom_range(0, 32'h6000)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 4) != 0), 1'b0);
      n_total++; if (bus.cfg_err !== m_exp_err) $display("FAIL rand_cfg_err: got %b expected %b", bus.cfg_err, m_exp_err); else n_pass++;
    end
    idle_cycle();
    for (int c = 0; c < NCH; c++) begin pend_v[c] = 1'b0; pend_exp[c] = '0; end
    for (int k = 0; k <= 60; k++) begin
      for (int c = 0; c < NCH; c++) begin
        n_total++;
        if ((bus.rsp_valid[c] !== pend_v[c]) || (pend_v[c] && (rsp_of(c) !== pend_exp[c])))
          $display("FAIL rand_ch%0d_cycle%0d: got valid=%b rsp=%h expected valid=%b rsp=%h",
                   c, k, bus.rsp_valid[c], rsp_of(c), pend_v[c], pend_exp[c]);
        else n_pass++;
        if ((k < 60) && ($urandom_range(0, 3) != 0)) begin
          sel = int'($urandom_range(0, 7));
          a = (sel == 0) ? (32'hFFFF_F000 | 32'($urandom_range(0, 4095))) : 32'($urandom_range(0, 32'h3_FFFF));
          l = (sel == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
          s = 3'($urandom_range(0, 7));
          drive_req(c, a, l, s);
          pend_v[c]   = 1'b1;
          pend_exp[c] = model_decode(a, l, s);
        end else begin
          bus.dec_valid[c] = 1'b0;
          pend_v[c]        = 1'b0;
        end
      end
      #1;
      n_total++; if (bus.dec_ready !== 2'b11) $display("FAIL rand_dec_ready: got %b expected 11", bus.dec_ready); else n_pass++;
      @(posedge clk); #1;
    end
    bus.dec_valid = '0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_a, exp_b;
    logic [6:0] exp_x [4];
    logic [31:0] xa;
    idle_cycle();
    bus.rsp_ready = 2'b01;
    exp_a = model_decode(32'h8010, 8'd0, 3'd0);
    exp_b = model_decode(32'h3_0000, 8'd1, 3'd2);
    drive_req(1, 32'h8010, 8'd0, 3'd0);
    xa = 32'h1000;
    exp_x[0] = model_decode(xa, 8'd0, 3'd2);
    drive_req(0, xa, 8'd0, 3'd2);
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      n_total++; if (rsp_of(0) !== exp_x[k-1] || bus.rsp_valid[0] !== 1'b1) $display("FAIL stall_ch0_stream%0d: got %h expected %h", k, rsp_of(0), exp_x[k-1]); else n_pass++;
      n_total++; if (rsp_of(1) !== exp_a || bus.rsp_valid[1] !== 1'b1) $display("FAIL stall_ch1_hold%0d: got %h expected %h", k, rsp_of(1), exp_a); else n_pass++;
      n_total++; if (bus.dec_ready[1] !== 1'b0) $display("FAIL stall_dec_ready%0d: got %b expected 0", k, bus.dec_ready[1]); else n_pass++;
      drive_req(1, 32'h3_0000, 8'd1, 3'd2);
      xa = 32'h1000 + 32'(k) * 32'h700;
      exp_x[k] = model_decode(xa, 8'(k), 3'd2);
      drive_req(0, xa, 8'(k), 3'd2);
      @(posedge clk); #1;
    end
    n_total++; if (rsp_of(0) !== exp_x[3]) $display("FAIL stall_ch0_last: got %h expected %h", rsp_of(0), exp_x[3]); else n_pass++;
    n_total++; if (rsp_of(1) !== exp_a) $display("FAIL stall_ch1_final_hold: got %h expected %h", rsp_of(1), exp_a); else n_pass++;
    bus.dec_valid[0] = 1'b0;
    bus.rsp_ready    = 2'b11;
    #1;
    n_total++; if (bus.dec_ready[1] !== 1'b1) $display("FAIL release_dec_ready: got %b expected 1", bus.dec_ready[1]); else n_pass++;
    @(posedge clk); #1;
    bus.dec_valid = '0;
    n_total++; if (rsp_of(1) !== exp_b) $display("FAIL release_ch1_next: got %h expected %h", rsp_of(1), exp_b); else n_pass++;
  endtask

  task automatic test_cfg_lock();
    logic [6:0] exp;
    cfg_write(3, 32'h2000, 32'h1000, 4'd1, 1'b1, 1'b0);
    n_total++; if (bus.cfg_err !== m_exp_err) $display("FAIL reject_inverted: got %b expected %b", bus.cfg_err, m_exp_err); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL reject_pulse_width: got %b expected 0", bus.cfg_err); else n_pass++;
    cfg_write(3, 32'h2000, 32'h1000, 4'd1, 1'b0, 1'b0);
    n_total++; if (bus.cfg_err !== m_exp_err) $display("FAIL accept_disabled_inverted: got %b expected %b", bus.cfg_err, m_exp_err); else n_pass++;
    cfg_write(5, 32'h6_0000, 32'h6_0FFF, 4'd12, 1'b1, 1'b1);
    n_total++; if (bus.cfg_err !== m_exp_err) $display("FAIL write_with_lock: got %b expected %b", bus.cfg_err, m_exp_err); else n_pass++;
    send(0, 32'h6_0100, 8'd0, 3'd0, exp);
    n_total++; if (rsp_of(0) !== exp) $display("FAIL lock_write_committed: got %h expected %h", rsp_of(0), exp); else n_pass++;
    cfg_write(0, 32'h0, 32'hFFFF_FFFF, 4'd15, 1'b1, 1'b0);
    n_total++; if (bus.cfg_err !== m_exp_err) $display("FAIL locked_reject: got %b expected %b", bus.cfg_err, m_exp_err); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL locked_pulse_width: got %b expected 0", bus.cfg_err); else n_pass++;
    send(1, 32'h5_0010, 8'd0, 3'd2, exp);
    n_total++; if (rsp_of(1) !== exp) $display("FAIL locked_table_unchanged: got %h expected %h", rsp_of(1), exp); else n_pass++;
  endtask

  task automatic test_reset_midburst();
    logic [6:0] exp;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      drive_req(0, 32'h8000 + 32'(k), 8'd0, 3'd0);
      drive_req(1, 32'h1_0000 + 32'(k), 8'd0, 3'd0);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL midrst_valid: got %b expected 00", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_region !== {2{4'(DEF)}}) $display("FAIL midrst_region: got %h expected %h", bus.rsp_region, {2{4'(DEF)}}); else n_pass++;
    n_total++; if ({bus.rsp_hit, bus.rsp_multi, bus.rsp_span_err} !== 6'b0) $display("FAIL midrst_flags: got %b expected 000000", {bus.rsp_hit, bus.rsp_multi, bus.rsp_span_err}); else n_pass++;
    model_reset();
    bus.dec_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL postrst_no_resp: got %b expected 00", bus.rsp_valid); else n_pass++;
    cfg_write(0, 32'h7_0000, 32'h7_0FFF, 4'd4, 1'b1, 1'b0);
    n_total++; if (bus.cfg_err !== m_exp_err) $display("FAIL postrst_lock_cleared: got %b expected %b", bus.cfg_err, m_exp_err); else n_pass++;
    send(0, 32'h7_0000, 8'd0, 3'd0, exp);
    n_total++; if (rsp_of(0) !== exp) $display("FAIL postrst_new_entry: got %h expected %h", rsp_of(0), exp); else n_pass++;
    send(1, 32'h8010, 8'd0, 3'd0, exp);
    n_total++; if (rsp_of(1) !== exp) $display("FAIL postrst_table_cleared: got %h expected %h", rsp_of(1), exp); else n_pass++;
  endtask

  initial begin
    rst            = 1'b1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_base   = '0;
    bus.cfg_limit  = '0;
    bus.cfg_region = '0;
    bus.cfg_enable = 1'b0;
    bus.cfg_lock   = 1'b0;
    bus.dec_valid  = '0;
    bus.dec_addr   = '0;
    bus.dec_len    = '0;
    bus.dec_size   = '0;
    bus.rsp_ready  = 2'b11;
    model_reset();

    test_reset();
    test_basic_hit();
    test_multi_match();
    test_span();
    test_same_cycle_write();
    test_random_stream();
    test_back_to_back();
    test_cfg_lock();
    test_reset_midburst();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
